// File: rtl/rf_seq_ctrl.sv
// Instruction sequencer for the single-port 8x16 register file. Accepts one
// register-transfer instruction at a time and time-multiplexes the shared
// address / read-write port across the read and write phases.
module rf_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [8:0]  instr,
    input  logic [15:0] imm,
    output logic        done,
    output logic        flag_z,
    output logic        flag_c,
    output logic [2:0]  rf_addr,
    output logic        rf_rd_wr,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata
);

    localparam logic [2:0] OpMv  = 3'b000;
    localparam logic [2:0] OpMvi = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdX  = 3'd1,
        StRdY  = 3'd2,
        StWr   = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, rx_q, ry_q;
    logic [15:0] imm_q, a_q, b_q;
    logic        flag_z_q, flag_c_q;

    logic        accept;
    logic        is_arith;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [15:0] result;

    assign accept   = instr_valid && instr_ready;
    assign is_arith = (op_q == OpAdd) || (op_q == OpSub);
    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    // Bit 16 of the 17-bit difference is the unsigned borrow (A < B).
    assign diff     = {1'b0, a_q} - {1'b0, b_q};

    // Result selection for the write phase.
    always_comb begin
        result = 16'h0000;
        case (op_q)
            OpMv:    result = b_q;
            OpMvi:   result = imm_q;
            OpAdd:   result = sum[15:0];
            OpSub:   result = diff[15:0];
            default: result = 16'h0000;
        endcase
    end

    // Next-state decode and port drive, all from registered state.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        rf_addr     = 3'd0;
        rf_rd_wr    = 1'b0;
        rf_wdata    = 16'h0000;
        unique case (state_q)
            StIdle: begin
                instr_ready = !reset;
                if (instr_valid && !reset) begin
                    case (instr[8:6])
                        OpMv:         state_d = StRdY;
                        OpMvi:        state_d = StWr;
                        OpAdd, OpSub: state_d = StRdX;
                        default:      state_d = StDone;
                    endcase
                end
            end
            StRdX: begin
                rf_addr = rx_q;
                state_d = StRdY;
            end
            StRdY: begin
                rf_addr = ry_q;
                state_d = StWr;
            end
            StWr: begin
                rf_addr  = rx_q;
                // Reset suppresses the write strobe so a reset cycle never writes.
                rf_rd_wr = !reset;
                rf_wdata = result;
                state_d  = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched instruction, operands and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 3'd0;
            rx_q     <= 3'd0;
            ry_q     <= 3'd0;
            imm_q    <= 16'h0000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= instr[8:6];
                rx_q  <= instr[5:3];
                ry_q  <= instr[2:0];
                imm_q <= imm;
            end
            if (state_q == StRdX) a_q <= rf_rdata;
            if (state_q == StRdY) b_q <= rf_rdata;
            if (state_q == StWr && is_arith) begin
                flag_c_q <= (op_q == OpAdd) ? sum[16] : diff[16];
                flag_z_q <= (result == 16'h0000);
            end
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

endmodule

// File: doc/rf_seq_ctrl.md
# rf_seq_ctrl

Instruction sequencer for the single-port 8×16-bit register file in the lab processor. It accepts one register-transfer instruction at a time over a valid/ready handshake. The register file has one shared address bus and one read/write select, so the block time-multiplexes that port across the read and write phases. It drives the port, computes the result, updates carry/zero flags and pulses `done` on completion. It sits between the instruction source (Qsys master or test FSM) and the register file.

## Interface
- No parameters; data width fixed at 16, register address 3 bits.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction present on `instr`/`imm`.
- `instr_ready` out 1: block is idle and accepts an instruction this cycle.
- `instr` in 9: `[8:6]` opcode, `[5:3]` Rx (destination / first operand), `[2:0]` Ry (second operand).
- `imm` in 16: immediate for `mvi`; sampled only at acceptance.
- `done` out 1: one-cycle pulse when the instruction retires.
- `flag_z` out 1: registered zero flag.
- `flag_c` out 1: registered carry/borrow flag.
- `rf_addr` out 3: register file address.
- `rf_rd_wr` out 1: 0 = read, 1 = write. The register file writes on the `clk` edge where this signal is 1.
- `rf_wdata` out 16: register file write data.
- `rf_rdata` in 16: register file read data. It is combinational from `rf_addr` and valid in the same cycle.

## Operation
- Opcodes:
  - 000 `mv`: Rx←Ry
  - 001 `mvi`: Rx←imm
  - 010 `add`: Rx←Rx+Ry
  - 011 `sub`: Rx←Rx−Ry
  - 100–111: no-op, no register write, flags unchanged.
- Acceptance: in IDLE, when `instr_valid` and `instr_ready` are both high at an edge, the block latches `instr` and `imm` into internal registers. Inputs are ignored at all other times.
- States and transitions:
  - IDLE: `instr_ready`=1. On acceptance, go to:
    - RD_X for `add`/`sub`
    - RD_Y for `mv`
    - WR for `mvi`
    - DONE for no-op.
  - RD_X: `rf_addr`=Rx, `rf_rd_wr`=0, capture operand A←`rf_rdata`; go to RD_Y.
  - RD_Y: `rf_addr`=Ry, `rf_rd_wr`=0, capture operand B←`rf_rdata`; go to WR.
  - WR: `rf_addr`=Rx, `rf_rd_wr`=1, `rf_wdata`=result; go to DONE. Result by opcode:
    - `mv`: B
    - `mvi`: latched imm
    - `add`: (A+B)[15:0]
    - `sub`: (A−B)[15:0]
  - DONE: `done`=1; go to IDLE.
- Port defaults: outside RD_X/RD_Y/WR, `rf_addr`=0 and `rf_rd_wr`=0. Outside WR, `rf_wdata`=0.
- Arithmetic is computed at 17 bits:
  - `add`: `flag_c`=bit 16 of A+B.
  - `sub`: `flag_c`=1 when A<B (unsigned borrow).
  - `add`/`sub`: `flag_z`=1 when the 16-bit result is 0.
  - Flags update at the WR edge for `add`/`sub` only. `mv`/`mvi` leave flags unchanged.
- Rx==Ry is legal: both reads return the same register, e.g. `add R2,R2` doubles R2 and `sub` yields 0 with Z=1.
- Back-to-back instructions: an instruction presented during DONE is not accepted. Acceptance occurs in the following IDLE cycle.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - state IDLE
  - `done`=0, `flag_z`=0, `flag_c`=0
  - `rf_addr`=0, `rf_rd_wr`=0, `rf_wdata`=0
- Gating while `reset` is high:
  - `instr_ready`=0
  - `rf_rd_wr` forced to 0, so no register write can occur in a reset cycle.
- Reset mid-instruction (any state): the instruction is abandoned, no write, no `done` pulse, flags cleared.
- Latency from the acceptance edge to the first cycle with `done`=1:
  - no-op: 1 cycle
  - `mvi`: 2 cycles
  - `mv`: 3 cycles
  - `add`/`sub`: 4 cycles
- Register write takes effect at the edge that ends WR. The new value is readable via `rf_rdata` in the DONE cycle.
- Issue interval = latency + 1 cycles minimum (DONE→IDLE→accept).
- `instr_ready` is combinational from state and reset. `done`, flags and port controls are decoded from registered state only; no combinational path from `instr_valid` to outputs other than none.

## Test plan
- Reset, then `mvi R3,0xBEEF`: WR cycle shows `rf_addr`=3, `rf_rd_wr`=1, `rf_wdata`=0xBEEF; `done` two cycles after accept; R3=0xBEEF.
- `mvi R1,0x0005`; `mvi R2,0x0003`; `sub R1,R2`: R1=0x0002, Z=0, C=0. Then `sub R2,R1`: R2=0x0001, C=0. Then `sub R2,R2`: R2=0, Z=1.
- `mvi R4,0xFFFF`; `mvi R5,0x0001`; `add R4,R5`: R4=0x0000, C=1, Z=1, `done` 4 cycles after accept.
- `mv R0,R4` after R4=0x1234: RD_Y drives `rf_addr`=4; R0=0x1234; flags unchanged from the prior instruction.
- Opcode 110 with `instr_valid` held high: `done` 1 cycle after accept, no write cycle, flags unchanged. The second accept occurs exactly 2 cycles after the first.
- `add` accepted, `reset` asserted in RD_Y: no `rf_rd_wr`=1 cycle, no `done`, flags 0, `instr_ready`=1 the cycle after `reset` deasserts.
